// File: rtl/pmod_led_pkg.sv
// pmod_led_pkg: mode encoding, per-mode initial patterns and LED width
package pmod_led_pkg;
  localparam int LED_WIDTH = 8;
  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;
  localparam logic [LED_WIDTH-1:0] INIT_COUNT = 8'h00;
  localparam logic [LED_WIDTH-1:0] INIT_SCAN  = 8'h01;
  localparam logic [LED_WIDTH-1:0] INIT_WALK  = 8'h01;
  localparam logic [LED_WIDTH-1:0] INIT_BLINK = 8'h00;
  function automatic logic [LED_WIDTH-1:0] init_pattern(input mode_t m);
    return m == MODE_COUNT ? INIT_COUNT :
           m == MODE_SCAN  ? INIT_SCAN  :
           m == MODE_WALK  ? INIT_WALK  : INIT_BLINK;
  endfunction
endpackage

// File: rtl/pmod_led_sequencer_debounce.sv
// button_debounce: 2-flop synchronizer, stable-level debouncer and rising-edge press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  assign accept  = (sync_q[1] != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign press_o = press_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      cnt_q    <= (sync_q[1] == stable_q || accept) ? '0 : cnt_q + CW'(1);
      stable_q <= accept ? sync_q[1] : stable_q;
      press_q  <= accept && sync_q[1];
    end
  end
endmodule

// File: rtl/pmod_led_sequencer.sv
// pmod_led_sequencer: button-selected stepped LED patterns with PWM dimming and heartbeat
module pmod_led_sequencer
  import pmod_led_pkg::*;
#(
  parameter int TICK_DIV        = 3000000,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int PWM_BITS        = 4,
  parameter int BRIGHTNESS      = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BTN,
  output logic [LED_WIDTH-1:0] PMOD,
  output logic                 LED,
  output logic [1:0]           MODE
);
  localparam int TW = $clog2(TICK_DIV);
  logic                 press;
  logic                 tick;
  logic                 on;
  logic [TW-1:0]        tick_cnt_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  mode_t                mode_q;
  mode_t                mode_nx;
  logic [LED_WIDTH-1:0] pattern_q;
  logic [LED_WIDTH-1:0] pattern_d;
  logic [LED_WIDTH-1:0] scan_nx;
  logic [LED_WIDTH-1:0] pmod_q;
  logic                 dir_up_q;
  logic                 dir_up_d;
  logic                 led_q;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .CLK     (CLK),
    .RST     (RST),
    .raw_i   (BTN),
    .press_o (press)
  );
  assign tick    = tick_cnt_q == TW'(TICK_DIV - 1);
  assign on      = {1'b0, pwm_cnt_q} < (PWM_BITS + 1)'(BRIGHTNESS);
  assign mode_nx = mode_t'(mode_q + 2'd1);
  assign scan_nx = dir_up_q ? pattern_q << 1 : pattern_q >> 1;
  assign PMOD    = pmod_q;
  assign LED     = led_q;
  assign MODE    = mode_q;
  always_comb begin
    pattern_d = mode_q == MODE_COUNT ? pattern_q + 8'd1 :
                mode_q == MODE_SCAN  ? scan_nx :
                mode_q == MODE_WALK  ? {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]} : ~pattern_q;
    dir_up_d  = (mode_q == MODE_SCAN && (scan_nx == 8'h80 || scan_nx == 8'h01)) ? ~dir_up_q : dir_up_q;
  end
  // a press overrides a coincident tick: no step, no heartbeat toggle, prescaler restarts
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      mode_q     <= MODE_COUNT;
      pattern_q  <= '0;
      dir_up_q   <= 1'b1;
      led_q      <= 1'b0;
      pmod_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      pmod_q    <= pattern_q & {LED_WIDTH{on}};
      if (press) begin
        mode_q     <= mode_nx;
        pattern_q  <= init_pattern(mode_nx);
        dir_up_q   <= 1'b1;
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) begin
          pattern_q <= pattern_d;
          dir_up_q  <= dir_up_d;
          led_q     <= ~led_q;
        end
      end
    end
  end
endmodule
